// File: rtl/predictor_stat_tracker.sv
// Tracks per-predictor accuracy (SP/LHP/GHP) by queueing issued predictions
// and scoring each one when its branch resolves, oldest first.
module predictor_stat_tracker #(
  parameter int STAT_COUNTER_WIDTH = 5,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pred_valid,
  input  logic                          SP_pred,
  input  logic                          LHP_pred,
  input  logic                          GHP_pred,
  input  logic                          resolve_valid,
  input  logic                          resolve_taken,
  input  logic                          flush,
  output logic [STAT_COUNTER_WIDTH-1:0] SP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0] LHP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0] GHP_stat_count,
  output logic [3:0]                    SP_trend_decode,
  output logic [3:0]                    LHP_trend_decode,
  output logic [3:0]                    GHP_trend_decode,
  output logic                          fifo_full,
  output logic                          fifo_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef logic [STAT_COUNTER_WIDTH-1:0] count_t;
  typedef logic [PTR_W:0]                ptr_t;
  typedef enum logic [1:0] {
    STRONG_DOWN = 2'd0,
    WEAK_DOWN   = 2'd1,
    WEAK_UP     = 2'd2,
    STRONG_UP   = 2'd3
  } trend_e;

  localparam count_t CNT_MAX  = '1;
  localparam count_t CNT_INIT = {1'b1, {(STAT_COUNTER_WIDTH-1){1'b0}}};
  localparam count_t CNT_ONE  = STAT_COUNTER_WIDTH'(1);
  localparam count_t CNT_TWO  = STAT_COUNTER_WIDTH'(2);
  localparam ptr_t   PTR_ONE  = (PTR_W+1)'(1);

  // Entry bit order: [2]=SP, [1]=LHP, [0]=GHP; same index for the stat arrays.
  logic [2:0]  fifo_mem [FIFO_DEPTH];
  ptr_t        wr_ptr, rd_ptr;
  count_t      count_q  [3];
  trend_e      trend_q  [3];
  logic [3:0]  decode_q [3];
  logic [2:0]  head;
  logic        push, pop;

  // Flags depend only on the pointer registers, never on this cycle's inputs.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign pop  = resolve_valid && !fifo_empty;
  assign push = pred_valid && !flush && (!fifo_full || pop);
  assign head = fifo_mem[rd_ptr[PTR_W-1:0]];

  function automatic count_t count_next(count_t c, logic hit);
    if (hit) return (c == CNT_MAX) ? c : c + CNT_ONE;
    return (c < CNT_TWO) ? '0 : c - CNT_TWO;
  endfunction

  function automatic trend_e trend_next(trend_e t, logic hit);
    case (t)
      STRONG_DOWN: return hit ? WEAK_DOWN : STRONG_DOWN;
      WEAK_DOWN:   return hit ? WEAK_UP   : STRONG_DOWN;
      WEAK_UP:     return hit ? STRONG_UP : WEAK_DOWN;
      default:     return hit ? STRONG_UP : WEAK_UP;
    endcase
  endfunction

  function automatic logic [3:0] trend_onehot(trend_e t);
    return 4'b0001 << t;
  endfunction

  // NOTE: the entry storage has no reset; an entry is only read after it has
  // been written, and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {SP_pred, LHP_pred, GHP_pred};
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < 3; i++) begin
        count_q[i]  <= CNT_INIT;
        trend_q[i]  <= WEAK_UP;
        decode_q[i] <= trend_onehot(WEAK_UP);
      end
    end else begin
      if (pop) begin
        for (int i = 0; i < 3; i++) begin
          count_q[i]  <= count_next(count_q[i], head[i] == resolve_taken);
          trend_q[i]  <= trend_next(trend_q[i], head[i] == resolve_taken);
          decode_q[i] <= trend_onehot(trend_next(trend_q[i], head[i] == resolve_taken));
        end
      end
      // A flush scores the head first (above), then discards every entry.
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  assign SP_stat_count    = count_q[2];
  assign LHP_stat_count   = count_q[1];
  assign GHP_stat_count   = count_q[0];
  assign SP_trend_decode  = decode_q[2];
  assign LHP_trend_decode = decode_q[1];
  assign GHP_trend_decode = decode_q[0];

endmodule

// File: doc/predictor_stat_tracker.md
PREDICTOR_STAT_TRACKER -- requirements
Module: predictor_stat_tracker

Interface
REQ-001 SHALL have parameter STAT_COUNTER_WIDTH, default 5: width of each per-predictor accuracy counter.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two: number of in-flight unresolved predictions held.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port pred_valid, input, 1: a branch prediction is issued this cycle.
REQ-007 SHALL have ports SP_pred, LHP_pred, GHP_pred, input, 1 each: the taken/not-taken direction from each sub-predictor for the issued branch.
REQ-008 SHALL have port resolve_valid, input, 1: the oldest in-flight branch resolves this cycle.
REQ-009 SHALL have port resolve_taken, input, 1: actual direction of the resolving branch.
REQ-010 SHALL have port flush, input, 1: discard all in-flight entries (wrong-path squash).
REQ-011 SHALL have ports SP_stat_count, LHP_stat_count, GHP_stat_count, output, STAT_COUNTER_WIDTH each: registered accuracy counters.
REQ-012 SHALL have ports SP_trend_decode, LHP_trend_decode, GHP_trend_decode, output, 4 each: registered one-hot trend state.
REQ-013 SHALL have port fifo_full, output, 1: no free entry, so upstream stalls prediction issue.
REQ-014 SHALL have port fifo_empty, output, 1: no in-flight entry.

Function
REQ-015 SHALL store {SP_pred, LHP_pred, GHP_pred} in a FIFO_DEPTH-entry FIFO on pred_valid, in issue order.
REQ-016 SHALL, on resolve_valid with FIFO non-empty, pop the head entry and compare each stored prediction bit against resolve_taken.
REQ-017 SHALL update each counter per predictor:
- correct: +1, saturating at 2^W-1.
- wrong: -2, saturating at 0 (a count of 1 goes to 0).
REQ-018 SHALL keep a 2-bit trend state per predictor, with states 3 strong-up, 2 weak-up, 1 weak-down, 0 strong-down:
- correct: +1, saturating at 3.
- wrong: -1, saturating at 0.
REQ-019 SHALL decode trend state one-hot as 3=4'b1000, 2=4'b0100, 1=4'b0010, 0=4'b0001; bit0 set means the downstream arbiter treats the count as zero.
REQ-020 SHALL register all outputs; a resolve in cycle N becomes visible on counts and trends in cycle N+1 (latency 1).
REQ-021 SHALL push on pred_valid only when not full, or when full with a simultaneous valid pop; otherwise the push SHALL be dropped and state left unchanged.
REQ-022 SHALL ignore resolve_valid when empty: no pop, no counter change.
REQ-023 SHALL handle simultaneous push and pop with occupancy unchanged and correct ordering, including when full or with one entry.
REQ-024 SHALL, on flush:
- still apply a same-cycle resolve_valid counter update from the head;
- then empty the FIFO;
- drop a same-cycle pred_valid push.
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH and derive full/empty from an extra pointer bit; both flags are registered-state functions with no input combinational path.
REQ-026 SHALL never alter counters or trends except on a valid pop.

Reset
REQ-027 SHALL, on rst high at a clock edge:
- empty the FIFO (fifo_empty=1, fifo_full=0);
- set all counts to 2^(W-1) (16 at default width);
- set all trend states to 2 (decode 4'b0100).
REQ-028 SHALL make rst dominant over pred_valid, resolve_valid and flush in the same cycle; in-flight entries are lost.

Verification
REQ-029 Reset, then push SP=1, LHP=0, GHP=1, then resolve taken=1 -> next cycle SP=17, LHP=14, GHP=17; SP/GHP trend 4'b1000, LHP 4'b0010.
REQ-030 Push 4 with no resolve -> fifo_full=1; 5th pred_valid dropped; 4 resolves pop the original 4 in issue order; fifo_empty=1 after the last.
REQ-031 Run 20 consecutive correct SP resolves from reset -> SP count saturates at 31, trend at 4'b1000; then 17 wrong -> count 0, trend 4'b0001, no underflow.
REQ-032 While full, push and resolve in the same cycle -> occupancy stays 4, fifo_full stays 1, the popped entry is the oldest, the new entry sits at the tail.
REQ-033 With 3 entries, assert flush with resolve_valid and pred_valid -> head counter update applied, fifo_empty=1 next cycle, pushed entry absent.
REQ-034 Assert resolve_valid on an empty FIFO, and assert rst mid-stream with entries in flight -> counts unchanged / restored to 16, trends 4'b0100, FIFO empty.
